stack_seq: RTL

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq_if.sv | 29 ++
 rtl/stack_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/stack_seq_if.sv
// Command and stack-port bundle for the stack sequencer.
// The slave modport is the sequencer. The master modport is the command issuer plus the stack storage.
interface stack_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        st_push;
  logic        st_pop;
  logic [31:0] st_data;
  logic [31:0] st_top;
  logic [31:0] st_top_m1;
  logic        st_full;
  logic [5:0]  st_ptr;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, st_top, st_top_m1, st_full, st_ptr,
    output cmd_ready, st_push, st_pop, st_data, result, result_valid, err, err_code
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, st_top, st_top_m1, st_full, st_ptr,
    input  cmd_ready, st_push, st_pop, st_data, result, result_valid, err, err_code
  );
endinterface

// File: rtl/stack_seq.sv
// Stack-machine sequencer: turns PUSH/POP/ALU commands into stack strobe sequences.
// The ALU result R is captured at acceptance, so later changes in stack contents cannot affect it.
module stack_seq (
  input  logic        clk,
  input  logic        rst,
  stack_seq_if.slave  bus
);
  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [2:0] {
    IDLE, S_PUSH, S_POP, S_POPA, S_POPB, S_PUSHR, S_ERR, S_NOP
  } state_t;

  state_t      state_q, state_d;
  logic        alive_q;
  logic [1:0]  code_q, code_d;
  logic [31:0] r_q, r_d;
  logic [31:0] result_q, result_d;
  logic [31:0] st_data_q, st_data_d;
  logic        accept;
  logic [31:0] alu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      alive_q   <= 1'b0;
      code_q    <= 2'b00;
      r_q       <= '0;
      result_q  <= '0;
      st_data_q <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= 1'b1;
      code_q    <= code_d;
      r_q       <= r_d;
      result_q  <= result_d;
      st_data_q <= st_data_d;
    end
  end

  always_comb begin
    alu = '0;
    case (bus.cmd_op)
      OP_ADD:  alu = bus.st_top_m1 + bus.st_top;
      OP_SUB:  alu = bus.st_top_m1 - bus.st_top;
      OP_AND:  alu = bus.st_top_m1 & bus.st_top;
      OP_OR:   alu = bus.st_top_m1 | bus.st_top;
      OP_XOR:  alu = bus.st_top_m1 ^ bus.st_top;
      default: alu = '0;
    endcase
  end

  // alive_q keeps cmd_ready low until the first clock edge after reset is released.
  assign accept = bus.cmd_valid && (state_q == IDLE) && alive_q;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    r_d       = r_q;
    result_d  = result_q;
    st_data_d = st_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_PUSH: begin
              if (bus.st_full) begin
                state_d = S_ERR;
                code_d  = 2'b10;
              end else begin
                state_d   = S_PUSH;
                st_data_d = bus.cmd_data;
                result_d  = bus.cmd_data;
              end
            end
            OP_POP: begin
              if (bus.st_ptr == 6'd0) begin
                state_d = S_ERR;
                code_d  = 2'b01;
              end else begin
                state_d  = S_POP;
                result_d = bus.st_top;
              end
            end
            OP_NOP: state_d = S_NOP;
            default: begin
              if (bus.st_ptr < 6'd2) begin
                state_d = S_ERR;
                code_d  = 2'b01;
              end else begin
                state_d = S_POPA;
                r_d     = alu;
              end
            end
          endcase
        end
      end
      S_POPA:  state_d = S_POPB;
      S_POPB: begin
        state_d   = S_PUSHR;
        st_data_d = r_q;
        result_d  = r_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready    = (state_q == IDLE) && alive_q;
  assign bus.st_push      = (state_q == S_PUSH) || (state_q == S_PUSHR);
  assign bus.st_pop       = (state_q == S_POP) || (state_q == S_POPA) || (state_q == S_POPB);
  assign bus.st_data      = st_data_q;
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == S_PUSH) || (state_q == S_POP) || (state_q == S_PUSHR);
  assign bus.err          = (state_q == S_ERR);
  assign bus.err_code     = (state_q == S_ERR) ? code_q : 2'b00;
endmodule
